// File: rtl/ex_tracker.sv
// ex_tracker: execute-stage trace tracker.
// Queues trace elements from the ID tracker and timestamps each element's EX
// phase and its data-memory request/grant handshake against the shared cycle
// counter. Completed elements go to the WB tracker with a one-cycle strobe.
// Elements flagged pass_through are forwarded untouched, in queue order.

package ex_tracker_pkg;

    // Start/end timestamp pair, in counter cycles.
    typedef struct packed {
        logic [31:0] time_start;
        logic [31:0] time_end;
    } time_span_t;

    // Trace element exchanged between the ID, EX and WB trackers.
    typedef struct packed {
        logic        pass_through;
        logic [31:0] pc;
        logic [31:0] insn;
        time_span_t  ex_data;
        time_span_t  mem_access_req;
    } trace_output;

endpackage

module ex_tracker
    import ex_tracker_pkg::*;
#(
    parameter int ADDR_WIDTH              = 32,
    parameter int DATA_WIDTH              = 32,
    parameter int PROCESSING_QUEUE_LENGTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] counter,
    input  logic        id_data_ready,
    input  trace_output id_data_i,
    input  logic        ex_ready,
    input  logic        data_req_i,
    input  logic        data_gnt_i,
    output logic        ex_data_ready,
    output trace_output ex_data_o,
    output logic        queue_overflow_o
);

    localparam int LEN   = PROCESSING_QUEUE_LENGTH;
    localparam int CNT_W = $clog2(LEN + 1);
    localparam int PTR_W = (LEN > 1) ? $clog2(LEN) : 1;

    // The trace element layout is fixed at 32-bit address/data; catch a
    // mismatched instantiation at elaboration rather than in the field.
    if (ADDR_WIDTH != 32 || DATA_WIDTH != 32 || LEN < 2) begin : g_param_check
        $error("ex_tracker: trace_output is 32-bit and the queue needs at least 2 entries");
    end

    typedef enum logic [1:0] {
        EX_IDLE,
        EX_CHECK,
        EX_WAIT_GNT
    } ex_state_t;

    ex_state_t   state_reg;
    trace_output trace_element;
    trace_output emit_elem;
    trace_output head_elem;

    trace_output      queue_mem [LEN];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic queue_full;
    logic do_pop;
    logic push_accept;

    assign queue_full  = (count_reg == CNT_W'(LEN));
    assign do_pop      = (state_reg == EX_IDLE) && (count_reg != '0);
    // A push at full is still accepted when the head leaves on the same edge.
    assign push_accept = id_data_ready && (!queue_full || do_pop);
    assign head_elem   = queue_mem[rd_ptr_reg];

    // Queue storage: write only, so no reset is needed on the array.
    always_ff @(posedge clk) begin
        if (push_accept) begin
            queue_mem[wr_ptr_reg] <= id_data_i;
        end
    end

    // Queue pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_reg       <= '0;
            wr_ptr_reg       <= '0;
            count_reg        <= '0;
            queue_overflow_o <= 1'b0;
        end else begin
            if (push_accept) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(LEN - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(LEN - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({push_accept, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (id_data_ready && !push_accept) begin
                queue_overflow_o <= 1'b1;
            end
        end
    end

    // The working element with this cycle's completion timestamps applied;
    // only meaningful on the cycle the FSM emits.
    always_comb begin
        emit_elem = trace_element;
        case (state_reg)
            EX_CHECK: begin
                if (data_req_i && data_gnt_i) begin
                    emit_elem.mem_access_req.time_start = counter;
                    emit_elem.mem_access_req.time_end   = counter;
                    emit_elem.ex_data.time_end          = counter;
                end else begin
                    emit_elem.ex_data.time_end = counter;
                end
            end
            EX_WAIT_GNT: begin
                emit_elem.mem_access_req.time_end = counter;
                emit_elem.ex_data.time_end        = counter;
            end
            default: ;
        endcase
    end

    // Tracking FSM with registered strobe and output element.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= EX_IDLE;
            trace_element <= '0;
            ex_data_ready <= 1'b0;
            ex_data_o     <= '0;
        end else begin
            ex_data_ready <= 1'b0;
            case (state_reg)
                EX_IDLE: begin
                    if (do_pop) begin
                        if (head_elem.pass_through) begin
                            ex_data_o     <= head_elem;
                            ex_data_ready <= 1'b1;
                        end else begin
                            trace_element                    <= head_elem;
                            trace_element.ex_data.time_start <= counter;
                            state_reg                        <= EX_CHECK;
                        end
                    end
                end
                EX_CHECK: begin
                    if (data_req_i && data_gnt_i) begin
                        trace_element <= emit_elem;
                        ex_data_o     <= emit_elem;
                        ex_data_ready <= 1'b1;
                        state_reg     <= EX_IDLE;
                    end else if (data_req_i) begin
                        trace_element.mem_access_req.time_start <= counter;
                        state_reg                               <= EX_WAIT_GNT;
                    end else if (ex_ready) begin
                        trace_element <= emit_elem;
                        ex_data_o     <= emit_elem;
                        ex_data_ready <= 1'b1;
                        state_reg     <= EX_IDLE;
                    end
                end
                EX_WAIT_GNT: begin
                    // ex_ready is deliberately ignored while a grant is pending.
                    if (data_gnt_i) begin
                        trace_element <= emit_elem;
                        ex_data_o     <= emit_elem;
                        ex_data_ready <= 1'b1;
                        state_reg     <= EX_IDLE;
                    end
                end
                default: state_reg <= EX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_tracker.sv
// Testbench for ex_tracker: directed stimulus with a scoreboard queue of
// expected output elements, checked by an independent strobe monitor.
module tb_ex_tracker;
    import ex_tracker_pkg::*;

    localparam int LEN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] counter = 32'd1;
    logic        id_data_ready = 1'b0;
    trace_output id_data_i = '0;
    logic        ex_ready = 1'b0;
    logic        data_req_i = 1'b0;
    logic        data_gnt_i = 1'b0;
    logic        ex_data_ready;
    trace_output ex_data_o;
    logic        queue_overflow_o;

    int total = 0;
    int passed = 0;
    int strobe_idx = 0;
    trace_output exp_q[$];
    trace_output mon_exp;
    trace_output e;

    ex_tracker #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .PROCESSING_QUEUE_LENGTH(LEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .counter(counter),
        .id_data_ready(id_data_ready),
        .id_data_i(id_data_i),
        .ex_ready(ex_ready),
        .data_req_i(data_req_i),
        .data_gnt_i(data_gnt_i),
        .ex_data_ready(ex_data_ready),
        .ex_data_o(ex_data_o),
        .queue_overflow_o(queue_overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic check_elem(input string name, input trace_output act, input trace_output exp);
        total++;
        if (act === exp) begin
            passed++;
            $display("ok   %s: pc=%h ex=%0d/%0d mem=%0d/%0d", name, act.pc,
                     act.ex_data.time_start, act.ex_data.time_end,
                     act.mem_access_req.time_start, act.mem_access_req.time_end);
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic trace_output mk(input logic pass, input logic [31:0] pc);
        trace_output t;
        t = '0;
        t.pass_through = pass;
        t.pc = pc;
        t.insn = pc ^ 32'hA5A5_0000;
        if (pass) begin
            // Arbitrary non-zero timestamps that must survive untouched.
            t.ex_data.time_start        = pc + 32'd1;
            t.ex_data.time_end          = pc + 32'd2;
            t.mem_access_req.time_start = pc + 32'd3;
            t.mem_access_req.time_end   = pc + 32'd4;
        end
        return t;
    endfunction

    // Inputs and the counter change 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        counter = counter + 32'd1;
    endtask

    task automatic wait_until(input logic [31:0] c);
        while (counter < c) tick();
    endtask

    task automatic push(input trace_output t);
        id_data_ready = 1'b1;
        id_data_i = t;
        tick();
        id_data_ready = 1'b0;
    endtask

    function automatic trace_output timed(input trace_output t, input int es, input int ee,
                                          input int ms, input int me);
        trace_output r;
        r = t;
        r.ex_data.time_start        = es;
        r.ex_data.time_end          = ee;
        r.mem_access_req.time_start = ms;
        r.mem_access_req.time_end   = me;
        return r;
    endfunction

    // Monitor: every strobe is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b1 && ex_data_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_strobe: got pc=%h expected no strobe", ex_data_o.pc);
            end else begin
                mon_exp = exp_q.pop_front();
                check_elem($sformatf("strobe%0d", strobe_idx), ex_data_o, mon_exp);
            end
            strobe_idx++;
        end
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check_bit("rst_ready", ex_data_ready, 1'b0);
        check_bit("rst_data_zero", (ex_data_o == '0), 1'b1);
        check_bit("rst_overflow", queue_overflow_o, 1'b0);
        rst = 1'b1;
        tick();

        // Non-memory element: pop at 11, ex_ready at 13
        wait_until(10);
        e = mk(1'b0, 32'h0000_1000);
        exp_q.push_back(timed(e, 11, 13, 0, 0));
        push(e);
        wait_until(13);
        ex_ready = 1'b1;
        tick();
        ex_ready = 1'b0;

        // Memory element, delayed grant: pop at 20, req at 21, gnt at 24
        wait_until(19);
        e = mk(1'b0, 32'h0000_2000);
        exp_q.push_back(timed(e, 20, 24, 21, 24));
        push(e);
        wait_until(21);
        data_req_i = 1'b1;
        wait_until(24);
        data_gnt_i = 1'b1;
        tick();
        data_req_i = 1'b0;
        data_gnt_i = 1'b0;

        // Same-cycle request and grant at 31
        wait_until(29);
        e = mk(1'b0, 32'h0000_3000);
        exp_q.push_back(timed(e, 30, 31, 31, 31));
        push(e);
        wait_until(31);
        data_req_i = 1'b1;
        data_gnt_i = 1'b1;
        tick();
        data_req_i = 1'b0;
        data_gnt_i = 1'b0;

        // Pass-through ordering A(pass), B(tracked), C(pass)
        wait_until(40);
        e = mk(1'b1, 32'h0000_4A00);
        exp_q.push_back(e);
        push(e);
        e = mk(1'b0, 32'h0000_4B00);
        exp_q.push_back(timed(e, 42, 44, 0, 0));
        push(e);
        e = mk(1'b1, 32'h0000_4C00);
        exp_q.push_back(e);
        push(e);
        wait_until(44);
        ex_ready = 1'b1;
        tick();
        ex_ready = 1'b0;

        // Overflow: D0 stalls in EX_CHECK, D1..D4 fill the queue, D5 dropped
        wait_until(50);
        e = mk(1'b0, 32'h0000_5000);
        exp_q.push_back(timed(e, 51, 60, 0, 0));
        push(e);
        for (int i = 1; i <= LEN; i++) begin
            e = mk(1'b0, 32'h0000_5000 + 32'(i) * 32'h10);
            exp_q.push_back(timed(e, 59 + 2 * i, 60 + 2 * i, 0, 0));
            push(e);
        end
        check_bit("overflow_before_full_push", queue_overflow_o, 1'b0);
        push(mk(1'b0, 32'h0000_5FF0));
        check_bit("overflow_set", queue_overflow_o, 1'b1);
        wait_until(60);
        ex_ready = 1'b1;
        wait_until(69);
        ex_ready = 1'b0;
        tick();
        check_bit("overflow_sticky", queue_overflow_o, 1'b1);

        // Reset asserted mid EX_WAIT_GNT: element abandoned, outputs clear at once
        wait_until(79);
        push(mk(1'b0, 32'h0000_6000));
        wait_until(81);
        data_req_i = 1'b1;
        wait_until(83);
        #2;
        rst = 1'b0;
        #1;
        check_bit("async_rst_ready", ex_data_ready, 1'b0);
        check_bit("async_rst_data_zero", (ex_data_o == '0), 1'b1);
        check_bit("async_rst_overflow", queue_overflow_o, 1'b0);
        data_req_i = 1'b0;
        tick();
        rst = 1'b1;
        data_gnt_i = 1'b1;
        repeat (3) tick();
        data_gnt_i = 1'b0;
        check_bit("post_rst_ready", ex_data_ready, 1'b0);
        check_bit("post_rst_overflow", queue_overflow_o, 1'b0);

        // Back in EX_IDLE with an empty queue: a pass element flows straight out
        wait_until(90);
        e = mk(1'b1, 32'h0000_7000);
        exp_q.push_back(e);
        push(e);

        // Bounded drain of outstanding expectations
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        tick();
        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: got %0d strobes outstanding expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
